// File: rtl/regfile_wb_ctrl_if.sv
// Writeback request channel between an execution producer and the register-file
// writeback controller: valid/ready handshake carrying up to two register writes.
interface regfile_wb_ctrl_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
);
  logic          wb_valid;
  logic          wb_ready;
  logic          wb_rd_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_rd_data;
  logic          wb_rs_en;
  logic [AW-1:0] wb_rs;
  logic [DW-1:0] wb_rs_data;

  modport master (
    output wb_valid, wb_rd_en, wb_rd, wb_rd_data, wb_rs_en, wb_rs, wb_rs_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_rd_en, wb_rd, wb_rd_data, wb_rs_en, wb_rs, wb_rs_data,
    output wb_ready
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Queues writeback entries and issues them to a two-write-port register file,
// splitting same-register Rd/Rs collisions so the Rd value lands last.
module regfile_wb_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  regfile_wb_ctrl_if.slave         wb,
  output logic                     RegWRd,
  output logic [AW-1:0]            Rd,
  output logic [DW-1:0]            busWd,
  output logic                     RegWRs,
  output logic [AW-1:0]            RsW,
  output logic [DW-1:0]            busWs,
  input  logic [AW-1:0]            chk_a,
  input  logic [AW-1:0]            chk_b,
  output logic                     hazard,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] rd;
    logic [DW-1:0] rd_data;
    logic          rs_en;
    logic [AW-1:0] rs;
    logic [DW-1:0] rs_data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT} state_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q;

  logic          rd_we_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] rd_data_q;
  logic          rs_we_q;
  logic [AW-1:0] rs_q;
  logic [DW-1:0] rs_data_q;
  logic [AW-1:0] split_rd_q;
  logic [DW-1:0] split_data_q;

  entry_t        head;
  entry_t        in_entry;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic          same_dst;
  logic [PW-1:0] off [DEPTH];
  logic          hit;

  assign wb.wb_ready = (count_q < CW'(DEPTH));
  assign push        = wb.wb_valid && wb.wb_ready;
  assign not_empty   = (count_q != '0);
  assign pop         = not_empty && (state_q != SPLIT);
  assign head        = mem_q[rptr_q];
  assign same_dst    = head.rd_en && head.rs_en && (head.rd == head.rs);

  always_comb begin
    in_entry.rd_en   = wb.wb_rd_en;
    in_entry.rd      = wb.wb_rd;
    in_entry.rd_data = wb.wb_rd_data;
    in_entry.rs_en   = wb.wb_rs_en;
    in_entry.rs      = wb.wb_rs;
    in_entry.rs_data = wb.wb_rs_data;
  end

  // Pending-write lookup: live FIFO slots, strobes on the wire, held split Rd.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off[i] = PW'(i) - rptr_q;
      if ({1'b0, off[i]} < count_q) begin
        if (mem_q[i].rd_en && ((mem_q[i].rd == chk_a) || (mem_q[i].rd == chk_b))) hit = 1'b1;
        if (mem_q[i].rs_en && ((mem_q[i].rs == chk_a) || (mem_q[i].rs == chk_b))) hit = 1'b1;
      end
    end
    if (rd_we_q && ((rd_q == chk_a) || (rd_q == chk_b))) hit = 1'b1;
    if (rs_we_q && ((rs_q == chk_a) || (rs_q == chk_b))) hit = 1'b1;
    if ((state_q == SPLIT) && ((split_rd_q == chk_a) || (split_rd_q == chk_b))) hit = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      rd_we_q      <= 1'b0;
      rd_q         <= '0;
      rd_data_q    <= '0;
      rs_we_q      <= 1'b0;
      rs_q         <= '0;
      rs_data_q    <= '0;
      split_rd_q   <= '0;
      split_data_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= in_entry;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);

      // Rs goes first on a collision so the Rd value is what the register keeps.
      case (state_q)
        IDLE, ISSUE: begin
          if (pop) begin
            if (same_dst) begin
              rd_we_q      <= 1'b0;
              rs_we_q      <= 1'b1;
              rs_q         <= head.rs;
              rs_data_q    <= head.rs_data;
              split_rd_q   <= head.rd;
              split_data_q <= head.rd_data;
              state_q      <= SPLIT;
            end else begin
              rd_we_q <= head.rd_en;
              rs_we_q <= head.rs_en;
              if (head.rd_en) begin
                rd_q      <= head.rd;
                rd_data_q <= head.rd_data;
              end
              if (head.rs_en) begin
                rs_q      <= head.rs;
                rs_data_q <= head.rs_data;
              end
              state_q <= ISSUE;
            end
          end else begin
            rd_we_q <= 1'b0;
            rs_we_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        SPLIT: begin
          rd_we_q   <= 1'b1;
          rs_we_q   <= 1'b0;
          rd_q      <= split_rd_q;
          rd_data_q <= split_data_q;
          state_q   <= not_empty ? ISSUE : IDLE;
        end
        default: begin
          rd_we_q <= 1'b0;
          rs_we_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign RegWRd = rd_we_q;
  assign Rd     = rd_q;
  assign busWd  = rd_data_q;
  assign RegWRs = rs_we_q;
  assign RsW    = rs_q;
  assign busWs  = rs_data_q;
  assign hazard = hit;
  assign count  = count_q;

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of queued writeback entries (power of 2, min 2).
REQ-002 Parameter AW, default 4, register address width (16 registers).
REQ-003 Parameter DW, default 32, register data width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wb_valid  input  1  producer offers a writeback entry.
REQ-007 wb_ready  output  1  controller accepts the entry; transfer when wb_valid && wb_ready at a rising edge.
REQ-008 wb_rd_en  input  1  entry carries a destination-register write.
REQ-009 wb_rd  input  AW  destination register address.
REQ-010 wb_rd_data  input  DW  destination write data.
REQ-011 wb_rs_en  input  1  entry carries a base-register (Rs1) update write.
REQ-012 wb_rs  input  AW  base register address.
REQ-013 wb_rs_data  input  DW  base write data.
REQ-014 RegWRd  output  1  register-file Rd write strobe.
REQ-015 Rd  output  AW  Rd write address.
REQ-016 busWd  output  DW  Rd write data.
REQ-017 RegWRs  output  1  register-file Rs write strobe.
REQ-018 RsW  output  AW  Rs write address.
REQ-019 busWs  output  DW  Rs write data.
REQ-020 chk_a, chk_b  input  AW each  read addresses to check for pending writes.
REQ-021 hazard  output  1  chk_a or chk_b matches a pending write.
REQ-022 count  output  log2(DEPTH)+1  number of queued entries.

Function
REQ-023 Entries shall be stored in a FIFO of DEPTH entries, drained in acceptance order.
REQ-024 wb_ready shall equal (count < DEPTH), registered-state only; push while full is refused even if a pop occurs the same cycle.
REQ-025 Write outputs (RegWRd, Rd, busWd, RegWRs, RsW, busWs) shall be registered; each strobe is high for exactly one cycle per issued write.
REQ-026 FSM states: IDLE, ISSUE, SPLIT.
REQ-027 IDLE/ISSUE with FIFO non-empty: pop head at the edge; if not (rd_en && rs_en && rd==rs), load both strobes from head enables and go/stay ISSUE.
REQ-028 Head with rd_en && rs_en && rd==rs: pop, assert only RegWRs (Rs data) this cycle, go to SPLIT.
REQ-029 SPLIT: assert only RegWRd with the held Rd data for one cycle, no pop; then ISSUE if FIFO non-empty else IDLE. Rd value is final in the register.
REQ-030 ISSUE/SPLIT exit with FIFO empty: strobes drop to 0, go IDLE.
REQ-031 Entry with neither enable shall be popped in one cycle with both strobes 0.
REQ-032 Latency: entry accepted at edge N into an empty FIFO in IDLE shall have its strobe(s) high in the cycle following edge N+1.
REQ-033 Throughput: one entry per cycle when no split; push and pop in the same cycle shall leave count unchanged.
REQ-034 Address/data outputs shall hold last values when strobes are 0.
REQ-035 hazard shall be combinational: match of chk_a or chk_b against any enabled address in valid FIFO entries, the currently asserted output strobes' addresses, or the pending SPLIT Rd.
REQ-036 Pointers shall wrap modulo DEPTH; count never exceeds DEPTH nor underflows.

Reset
REQ-037 On reset: FIFO flushed, count=0, FSM IDLE, RegWRd=RegWRs=0, Rd=RsW=0, busWd=busWs=0, held SPLIT data discarded.
REQ-038 Reset mid-operation (including SPLIT) shall drop all pending writes; no strobe in the cycle after reset.
REQ-039 wb_ready shall be 1 in the cycle after reset deasserts.

Verification
REQ-040 Single entry rd_en=1 wb_rd=3 data=0xDEADBEEF -> RegWRd=1 Rd=3 busWd=0xDEADBEEF for one cycle two edges after accept; RegWRs=0.
REQ-041 Entry rd=5/0x11, rs=5/0x22 both enabled -> cycle k RegWRs=1 RsW=5 busWs=0x22, cycle k+1 RegWRd=1 Rd=5 busWd=0x11.
REQ-042 Five back-to-back pushes with drain stalled by splits -> wb_ready=0 at count=4, refused entry never written, order preserved.
REQ-043 Queue rd=7; chk_a=7 -> hazard=1 until cycle after RegWRd for 7; chk_a=8 -> hazard=0.
REQ-044 Reset asserted during SPLIT with 2 entries queued -> no further strobes, count=0, wb_ready=1 after release.
REQ-045 Entry both enables 0 -> popped, count decrements, no strobe.
